// File: rtl/rd53_afe_bgpv_inj_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rd53_afe_bgpv_pkg
// Shared types for the BGPV AFE injection sequencer:
//   - bgpv_inj_state_t : burst sequencer states
//   - bgpv_afe_cfg_t   : AFE static configuration (gain, power-down, trim DAC)
//   - TH_DAC_W         : width of the threshold trim DAC
// ---------------------------------------------------------------------------
package rd53_afe_bgpv_pkg;

  localparam int unsigned TH_DAC_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_PRE    = 3'd2,
    ST_INJ    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_GAP    = 3'd5,
    ST_DONE   = 3'd6
  } bgpv_inj_state_t;

  typedef struct packed {
    logic                gain_sel;
    logic                power_down;
    logic [TH_DAC_W-1:0] th_dac;
  } bgpv_afe_cfg_t;

  // The AFE comes out of reset powered down with default trim.
  localparam bgpv_afe_cfg_t CFG_RESET = '{gain_sel: 1'b0, power_down: 1'b1, th_dac: '0};

  function automatic logic is_busy(input bgpv_inj_state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/rd53_afe_bgpv_inj_ctrl_if.sv
// ---------------------------------------------------------------------------
// rd53_afe_bgpv_inj_ctrl_if
// BGPV digital AFE control interface.
//   S0, S1      : calibration injection pulses
//   GAIN_SEL    : gain select
//   POWER_DOWN  : front-end power down
//   TH_DAC      : threshold trim DAC
//   HIT         : asynchronous discriminator output (AFE -> digital)
// Modports: master = front-end control side (fe_control), slave = AFE side.
// ---------------------------------------------------------------------------
interface rd53_afe_bgpv_inj_ctrl_if;
  import rd53_afe_bgpv_pkg::*;

  logic                S0;
  logic                S1;
  logic                GAIN_SEL;
  logic                POWER_DOWN;
  logic [TH_DAC_W-1:0] TH_DAC;
  logic                HIT;

  modport master (
    output S0, S1, GAIN_SEL, POWER_DOWN, TH_DAC,
    input  HIT
  );

  modport fe_control (
    output S0, S1, GAIN_SEL, POWER_DOWN, TH_DAC,
    input  HIT
  );

  modport slave (
    input  S0, S1, GAIN_SEL, POWER_DOWN, TH_DAC,
    output HIT
  );

endinterface

// File: rtl/rd53_afe_bgpv_inj_ctrl_sync_edge.sv
// ---------------------------------------------------------------------------
// rd53_sync_edge
// Multi-flop synchroniser for an asynchronous level plus rising-edge detect.
//   clk, rst  : clock, asynchronous active-high reset
//   async_in  : asynchronous input level
//   rise      : one-cycle pulse on a synchronised 0->1 transition
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module rd53_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/rd53_afe_bgpv_inj_ctrl.sv
// ---------------------------------------------------------------------------
// rd53_afe_bgpv_inj_ctrl
// Per-pixel BGPV AFE sequencer: holds AFE configuration, runs a burst of
// S0/S1 calibration injections and counts injections that produced a hit.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   cfg_we, cfg_gain_sel,
//   cfg_power_down, cfg_th_dac    : configuration write (IDLE only)
//   start, abort                  : burst control
//   n_inj                         : injections per burst
//   pulse_w, win_len, gap_len     : S0/S1 width, hit window, inter-injection gap
//   busy, done, hit_cnt, pd_err   : status
//   afe                           : AFE control interface (master modport)
// ---------------------------------------------------------------------------
module rd53_afe_bgpv_inj_ctrl
  import rd53_afe_bgpv_pkg::*;
#(
  parameter int unsigned N_INJ_W     = 8,
  parameter int unsigned TIMER_W     = 8,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic                cfg_gain_sel,
  input  logic                cfg_power_down,
  input  logic [TH_DAC_W-1:0] cfg_th_dac,
  input  logic                start,
  input  logic                abort,
  input  logic [N_INJ_W-1:0]  n_inj,
  input  logic [TIMER_W-1:0]  pulse_w,
  input  logic [TIMER_W-1:0]  win_len,
  input  logic [TIMER_W-1:0]  gap_len,
  output logic                busy,
  output logic                done,
  output logic [N_INJ_W-1:0]  hit_cnt,
  output logic                pd_err,
  rd53_afe_bgpv_inj_ctrl_if.master afe
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  // Two spare bits cover win_len + SYNC_STAGES without wrapping.
  localparam int unsigned TMR_W = ((TIMER_W + 2) > SET_W) ? (TIMER_W + 2) : SET_W;

  bgpv_inj_state_t     state_q, state_n;
  logic [TMR_W-1:0]    timer_q, timer_n;
  logic [N_INJ_W-1:0]  inj_q, inj_n;
  bgpv_afe_cfg_t       cfg_q;
  logic                dirty_q;
  logic                hit_seen_q;
  logic                s0_q, s1_q;

  logic                hit_rise;
  logic                start_acc;
  logic                settle_exit;
  logic                win_exit;
  logic                inj_end;
  logic [TMR_W-1:0]    pw_m1, win_m1, gap_m1, settle_m1;

  rd53_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_hit_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (afe.HIT),
    .rise     (hit_rise)
  );

  // Timers count down from length-1 to 0; lengths are sampled at each load.
  assign pw_m1     = (pulse_w == '0) ? '0 : (TMR_W'(pulse_w) - TMR_W'(1));
  assign win_m1    = TMR_W'(win_len) + TMR_W'(SYNC_STAGES) - TMR_W'(1);
  assign gap_m1    = TMR_W'(gap_len) - TMR_W'(1);
  assign settle_m1 = TMR_W'(SETTLE_CYC - 1);

  always_comb begin
    state_n     = state_q;
    timer_n     = timer_q;
    inj_n       = inj_q;
    start_acc   = 1'b0;
    settle_exit = 1'b0;
    win_exit    = 1'b0;
    inj_end     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          start_acc = 1'b1;
          if (cfg_q.power_down || (n_inj == '0)) begin
            state_n = ST_DONE;
          end else begin
            inj_n = n_inj;
            if (dirty_q) begin
              state_n = ST_SETTLE;
              timer_n = settle_m1;
            end else begin
              state_n = ST_PRE;
              timer_n = pw_m1;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (timer_q == '0) begin
          settle_exit = 1'b1;
          state_n     = ST_PRE;
          timer_n     = pw_m1;
        end else begin
          timer_n = timer_q - TMR_W'(1);
        end
      end
      ST_PRE: begin
        if (timer_q == '0) begin
          state_n = ST_INJ;
          timer_n = pw_m1;
        end else begin
          timer_n = timer_q - TMR_W'(1);
        end
      end
      ST_INJ: begin
        if (timer_q == '0) begin
          state_n = ST_WAIT;
          timer_n = win_m1;
        end else begin
          timer_n = timer_q - TMR_W'(1);
        end
      end
      ST_WAIT: begin
        if (timer_q == '0) begin
          win_exit = 1'b1;
          // A zero gap skips GAP entirely; the injection ends right here.
          if (gap_len == '0) begin
            inj_end = 1'b1;
          end else begin
            state_n = ST_GAP;
            timer_n = gap_m1;
          end
        end else begin
          timer_n = timer_q - TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          inj_end = 1'b1;
        end else begin
          timer_n = timer_q - TMR_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    if (inj_end) begin
      inj_n = inj_q - N_INJ_W'(1);
      if (inj_q == N_INJ_W'(1)) begin
        state_n = ST_DONE;
      end else begin
        state_n = ST_PRE;
        timer_n = pw_m1;
      end
    end

    if (abort && is_busy(state_q)) begin
      state_n     = ST_IDLE;
      settle_exit = 1'b0;
      win_exit    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      inj_q      <= '0;
      cfg_q      <= CFG_RESET;
      dirty_q    <= 1'b1;
      hit_seen_q <= 1'b0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit_cnt    <= '0;
      pd_err     <= 1'b0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
      inj_q   <= inj_n;
      s0_q    <= (state_n == ST_PRE);
      s1_q    <= (state_n == ST_INJ);
      busy    <= is_busy(state_n);
      done    <= (state_n == ST_DONE);

      if ((state_q == ST_IDLE) && cfg_we) begin
        cfg_q   <= '{gain_sel: cfg_gain_sel, power_down: cfg_power_down, th_dac: cfg_th_dac};
        dirty_q <= 1'b1;
      end else if (settle_exit) begin
        dirty_q <= 1'b0;
      end

      if (state_q == ST_PRE) begin
        hit_seen_q <= 1'b0;
      end else if (hit_rise && ((state_q == ST_INJ) || (state_q == ST_WAIT))) begin
        hit_seen_q <= 1'b1;
      end

      // An edge landing in the final WAIT cycle still belongs to the window.
      if (start_acc) begin
        hit_cnt <= '0;
        pd_err  <= cfg_q.power_down;
      end else if (win_exit && (hit_seen_q || hit_rise)) begin
        hit_cnt <= hit_cnt + N_INJ_W'(1);
      end
    end
  end

  assign afe.S0         = s0_q;
  assign afe.S1         = s1_q;
  assign afe.GAIN_SEL   = cfg_q.gain_sel;
  assign afe.POWER_DOWN = cfg_q.power_down;
  assign afe.TH_DAC     = cfg_q.th_dac;

endmodule

// File: tb/tb_rd53_afe_bgpv_inj_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rd53_afe_bgpv_inj_ctrl
// Directed self-checking bench for rd53_afe_bgpv_inj_ctrl.
// ---------------------------------------------------------------------------
module tb_rd53_afe_bgpv_inj_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic       cfg_gain_sel = 1'b0;
  logic       cfg_power_down = 1'b0;
  logic [3:0] cfg_th_dac = 4'h0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] n_inj = 8'd0;
  logic [7:0] pulse_w = 8'd0;
  logic [7:0] win_len = 8'd0;
  logic [7:0] gap_len = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] hit_cnt;
  logic       pd_err;

  int total = 0;
  int bad   = 0;

  rd53_afe_bgpv_inj_ctrl_if afe ();

  rd53_afe_bgpv_inj_ctrl #(
    .N_INJ_W     (8),
    .TIMER_W     (8),
    .SETTLE_CYC  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_gain_sel   (cfg_gain_sel),
    .cfg_power_down (cfg_power_down),
    .cfg_th_dac     (cfg_th_dac),
    .start          (start),
    .abort          (abort),
    .n_inj          (n_inj),
    .pulse_w        (pulse_w),
    .win_len        (win_len),
    .gap_len        (gap_len),
    .busy           (busy),
    .done           (done),
    .hit_cnt        (hit_cnt),
    .pd_err         (pd_err),
    .afe            (afe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_s1(input string tag);
    int n = 0;
    while (afe.S1 !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, afe.S1, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, done, 1);
  endtask

  task automatic cfg_write(input logic gs, input logic pd, input logic [3:0] th);
    cfg_we = 1'b1; cfg_gain_sel = gs; cfg_power_down = pd; cfg_th_dac = th;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic kick(input logic [7:0] n, input logic [7:0] pw, input logic [7:0] wl,
                      input logic [7:0] gl);
    n_inj = n; pulse_w = pw; win_len = wl; gap_len = gl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    afe.HIT = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_s0", afe.S0, 0);
    chk("rst_s1", afe.S1, 0);
    chk("rst_gain", afe.GAIN_SEL, 0);
    chk("rst_pd", afe.POWER_DOWN, 1);
    chk("rst_th", afe.TH_DAC, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hitcnt", hit_cnt, 0);
    chk("rst_pderr", pd_err, 0);
    rst = 1'b0;
    tick();

    // Configure, then a single injection through SETTLE
    cfg_write(1'b1, 1'b0, 4'hA);
    chk("cfg_gain", afe.GAIN_SEL, 1);
    chk("cfg_pd", afe.POWER_DOWN, 0);
    chk("cfg_th", afe.TH_DAC, 4'hA);
    kick(8'd1, 8'd3, 8'd2, 8'd1);
    for (int i = 0; i < 16; i++) begin
      chk("settle_s0", afe.S0, 0);
      chk("settle_busy", busy, 1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("pre_s0", afe.S0, 1);
      chk("pre_s1", afe.S1, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("inj_s1", afe.S1, 1);
      chk("inj_s0", afe.S0, 0);
      tick();
    end
    // WAIT = win_len + 2 sync stages = 4 cycles, then GAP = 1 cycle
    for (int i = 0; i < 5; i++) begin
      chk("tail_s0", afe.S0, 0);
      chk("tail_s1", afe.S1, 0);
      chk("tail_busy", busy, 1);
      chk("tail_done", done, 0);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_hitcnt", hit_cnt, 0);
    tick();
    chk("t1_done_off", done, 0);

    // Five injections, hits in 1, 3, 5, zero gap
    kick(8'd5, 8'd2, 8'd4, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      wait_s1("t2_s1");
      if (k % 2 == 1) afe.HIT = 1'b1;
      tick(); tick();
      afe.HIT = 1'b0;
    end
    wait_done("t2_done");
    chk("t2_hitcnt", hit_cnt, 3);
    chk("t2_busy", busy, 0);
    tick();

    // Three edges inside one window count once
    kick(8'd1, 8'd2, 8'd10, 8'd3);
    wait_s1("t3a_s1");
    for (int i = 0; i < 3; i++) begin
      afe.HIT = 1'b1; tick();
      afe.HIT = 1'b0; tick();
    end
    wait_done("t3a_done");
    chk("t3a_hitcnt", hit_cnt, 1);
    tick();

    // Start while powered down
    cfg_write(1'b1, 1'b1, 4'hA);
    chk("t5a_pd", afe.POWER_DOWN, 1);
    kick(8'd3, 8'd2, 8'd2, 8'd2);
    chk("t5a_done", done, 1);
    chk("t5a_busy", busy, 0);
    chk("t5a_pderr", pd_err, 1);
    chk("t5a_hitcnt", hit_cnt, 0);
    chk("t5a_s0", afe.S0, 0);
    tick();
    chk("t5a_done_off", done, 0);
    chk("t5a_s0b", afe.S0, 0);
    chk("t5a_s1b", afe.S1, 0);

    // n_inj = 0
    cfg_write(1'b1, 1'b0, 4'hA);
    kick(8'd0, 8'd2, 8'd2, 8'd2);
    chk("t5b_done", done, 1);
    chk("t5b_pderr", pd_err, 0);
    chk("t5b_busy", busy, 0);
    tick();
    chk("t5b_done_off", done, 0);

    // HIT edge during GAP is ignored (window c0..c0+5, GAP from c0+6)
    kick(8'd1, 8'd2, 8'd2, 8'd8);
    wait_s1("t3b_s1");
    repeat (7) tick();
    afe.HIT = 1'b1;
    wait_done("t3b_done");
    chk("t3b_hitcnt", hit_cnt, 0);
    tick();

    // HIT held high across the window: no edge, no count
    kick(8'd1, 8'd2, 8'd2, 8'd2);
    wait_done("t3c_done");
    chk("t3c_hitcnt", hit_cnt, 0);
    afe.HIT = 1'b0;
    tick();

    // Back-to-back without reconfiguration: no SETTLE
    kick(8'd1, 8'd2, 8'd1, 8'd1);
    chk("t4_s0", afe.S0, 1);
    chk("t4_busy", busy, 1);
    wait_done("t4_done");
    tick();

    // cfg_we during a burst, then abort in WAIT of injection 2 of 4
    kick(8'd4, 8'd2, 8'd3, 8'd2);
    cfg_write(1'b0, 1'b1, 4'h5);
    chk("t6_th", afe.TH_DAC, 4'hA);
    chk("t6_pd", afe.POWER_DOWN, 0);
    chk("t6_gain", afe.GAIN_SEL, 1);
    wait_s1("t6_s1a");
    afe.HIT = 1'b1;
    tick(); tick();
    afe.HIT = 1'b0;
    wait_s1("t6_s1b");
    tick(); tick();
    chk("t6_hit_pre", hit_cnt, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_s0", afe.S0, 0);
    chk("t6_s1", afe.S1, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_hitcnt", hit_cnt, 1);
    tick();
    chk("t6_done2", done, 0);
    chk("t6_busy2", busy, 0);

    // Asynchronous reset mid-burst
    kick(8'd2, 8'd2, 8'd2, 8'd2);
    wait_s1("t7_s1");
    #2;
    rst = 1'b1;
    #1;
    chk("t7_s1", afe.S1, 0);
    chk("t7_busy", busy, 0);
    chk("t7_pd", afe.POWER_DOWN, 1);
    chk("t7_gain", afe.GAIN_SEL, 0);
    chk("t7_th", afe.TH_DAC, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
